// File: rtl/debug_sbus_responder.sv
// Debug system bus responder: turns single-cycle sbread/sbwrite pulses into one
// valid/ready word-bus transaction each, with lane steering, error and timeout reporting.
module debug_sbus_responder #(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int TO_W           = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] sbaddr,
  input  logic [31:0] sbdata_o,
  input  logic [2:0]  sbsize,
  input  logic        sbread,
  input  logic        sbwrite,
  output logic [31:0] sbdata_i,
  output logic        sbbusy,
  output logic        sberror,
  output logic        mem_valid,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // Last REQ cycle index before giving up; mem_valid stays up TIMEOUT_CYCLES cycles.
  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  logic [1:0]      state_q, state_d;
  logic            mem_we_q, mem_we_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;
  logic [3:0]      mem_wstrb_q, mem_wstrb_d;
  logic [1:0]      lane_q, lane_d;
  logic [1:0]      size_q, size_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [31:0]     sbdata_q, sbdata_d;
  logic            sberror_q, sberror_d;

  logic            accept;
  logic            illegal;
  logic [31:0]     wr_data;
  logic [3:0]      wr_strb;
  logic [31:0]     rd_shift;
  logic [31:0]     rd_ext;
  logic            timeout_hit;

  assign accept = (state_q == IDLE) && (sbread || sbwrite);

  assign illegal = (sbsize > 3'd2)
                || ((sbsize == 3'd1) && sbaddr[0])
                || ((sbsize == 3'd2) && (sbaddr[1:0] != 2'b00))
                || (sbread && sbwrite);

  always_comb begin
    wr_data = sbdata_o;
    wr_strb = 4'b1111;
    case (sbsize[1:0])
      2'd0: begin
        wr_data = {4{sbdata_o[7:0]}};
        wr_strb = 4'b0001 << sbaddr[1:0];
      end
      2'd1: begin
        wr_data = {2{sbdata_o[15:0]}};
        wr_strb = sbaddr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wr_data = sbdata_o;
        wr_strb = 4'b1111;
      end
    endcase
    if (!sbwrite) begin
      wr_strb = 4'b0000;
    end
  end

  // Halves are always lane-aligned, so one byte-granular shift serves both narrow sizes.
  assign rd_shift = mem_rdata >> {lane_q, 3'b000};

  always_comb begin
    case (size_q)
      2'd0:    rd_ext = {24'h0, rd_shift[7:0]};
      2'd1:    rd_ext = {16'h0, rd_shift[15:0]};
      default: rd_ext = mem_rdata;
    endcase
  end

  assign timeout_hit = TO_EN && (to_q == TO_LAST);

  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    lane_d      = lane_q;
    size_d      = size_q;
    to_d        = to_q;
    sbdata_d    = sbdata_q;
    sberror_d   = sberror_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          sbdata_d  = 32'h0;
          sberror_d = 1'b0;
          to_d      = '0;
          lane_d    = sbaddr[1:0];
          size_d    = sbsize[1:0];
          if (illegal) begin
            sberror_d = 1'b1;
            state_d   = RESP;
          end else begin
            mem_we_d    = sbwrite;
            mem_addr_d  = {sbaddr[31:2], 2'b00};
            mem_wdata_d = sbwrite ? wr_data : 32'h0;
            mem_wstrb_d = wr_strb;
            state_d     = REQ;
          end
        end
      end
      REQ: begin
        to_d = to_q + 1'b1;
        if (mem_ready) begin
          sberror_d = mem_err;
          if (!mem_we_q && !mem_err) begin
            sbdata_d = rd_ext;
          end
          state_d = RESP;
        end else if (timeout_hit) begin
          sberror_d = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_wstrb_q <= 4'h0;
      lane_q      <= 2'd0;
      size_q      <= 2'd0;
      to_q        <= '0;
      sbdata_q    <= 32'h0;
      sberror_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      lane_q      <= lane_d;
      size_q      <= size_d;
      to_q        <= to_d;
      sbdata_q    <= sbdata_d;
      sberror_q   <= sberror_d;
    end
  end

  // Busy is combinational so the debug module sees it in the pulse cycle itself.
  assign sbbusy    = ((state_q != IDLE) && (state_q != RESP)) || accept;
  assign mem_valid = (state_q == REQ);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign sbdata_i  = sbdata_q;
  assign sberror   = sberror_q;

endmodule

// File: tb/tb_debug_sbus_responder.sv
// Bench for debug_sbus_responder: directed vector table, reset-in-flight sequence
// and randomized transactions checked against a rule-level reference model.
module tb_debug_sbus_responder;

  localparam int T = 4;

  logic        clk;
  logic        rst;
  logic [31:0] sbaddr;
  logic [31:0] sbdata_o;
  logic [2:0]  sbsize;
  logic        sbread;
  logic        sbwrite;
  logic [31:0] sbdata_i;
  logic        sbbusy;
  logic        sberror;
  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  size;
    logic        rd;
    logic        wr;
    int          delay;
    logic [31:0] rdata;
    logic        err;
    logic        expErr;
    logic [31:0] expRdata;
    logic [3:0]  expWstrb;
    logic [31:0] expWdata;
  } vec_t;

  debug_sbus_responder #(.TIMEOUT_CYCLES(T), .TO_W(10)) dut (
    .clk(clk), .rst(rst),
    .sbaddr(sbaddr), .sbdata_o(sbdata_o), .sbsize(sbsize),
    .sbread(sbread), .sbwrite(sbwrite),
    .sbdata_i(sbdata_i), .sbbusy(sbbusy), .sberror(sberror),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mkVec(input string name, input logic [31:0] addr, input logic [31:0] data,
                                 input logic [2:0] size, input logic rd, input logic wr, input int delay,
                                 input logic [31:0] rdata, input logic err, input logic expErr,
                                 input logic [31:0] expRdata, input logic [3:0] expWstrb,
                                 input logic [31:0] expWdata);
    vec_t v;
    v.name = name; v.addr = addr; v.data = data; v.size = size; v.rd = rd; v.wr = wr;
    v.delay = delay; v.rdata = rdata; v.err = err; v.expErr = expErr; v.expRdata = expRdata;
    v.expWstrb = expWstrb; v.expWdata = expWdata;
    return v;
  endfunction

  // Reference model: legality and lane rules stated as plain arithmetic on byte counts.
  function automatic bit isLegal(input vec_t v);
    if (v.rd && v.wr) return 1'b0;
    if (v.size > 3'd2) return 1'b0;
    return (v.addr % (32'd1 << v.size)) == 32'd0;
  endfunction

  function automatic vec_t fillExpected(input vec_t v);
    vec_t r;
    int nb;
    int lane;
    logic [31:0] mask;
    r = v;
    r.expErr = 1'b1; r.expRdata = 32'h0; r.expWstrb = 4'h0; r.expWdata = 32'h0;
    if (isLegal(v)) begin
      nb = 1 << v.size;
      lane = int'(v.addr % 32'd4);
      if (v.wr) begin
        r.expWstrb = 4'(((1 << nb) - 1) << lane);
        for (int i = 0; i < 4; i++) r.expWdata[8*i +: 8] = v.data[8*(i % nb) +: 8];
      end
      if (v.delay < T) begin
        r.expErr = v.err;
        if (v.rd && !v.err) begin
          mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*nb)) - 32'd1);
          r.expRdata = (v.rdata >> (8*lane)) & mask;
        end
      end
    end
    return r;
  endfunction

  // Called at posedge+1; returns at posedge+1 of the first cycle a new pulse may be issued.
  task automatic applyStimulus(input vec_t v);
    int expValid;
    sbaddr = v.addr; sbdata_o = v.data; sbsize = v.size; sbread = v.rd; sbwrite = v.wr;
    #1;
    checkOutput({v.name, "_busy_pulse"}, 32'(sbbusy), 32'd1);
    @(posedge clk); #1;
    sbread = 1'b0; sbwrite = 1'b0;
    sbaddr = $urandom; sbdata_o = $urandom; sbsize = 3'($urandom);
    if (!isLegal(v)) begin
      checkOutput({v.name, "_resp_busy"}, 32'(sbbusy), 32'd0);
      checkOutput({v.name, "_resp_valid"}, 32'(mem_valid), 32'd0);
      checkOutput({v.name, "_resp_err"}, 32'(sberror), 32'(v.expErr));
      checkOutput({v.name, "_resp_data"}, sbdata_i, v.expRdata);
    end else begin
      expValid = (v.delay < T) ? v.delay + 1 : T;
      for (int k = 0; k < expValid; k++) begin
        checkOutput({v.name, "_req_valid"}, 32'(mem_valid), 32'd1);
        checkOutput({v.name, "_req_busy"}, 32'(sbbusy), 32'd1);
        checkOutput({v.name, "_req_addr"}, mem_addr, {v.addr[31:2], 2'b00});
        checkOutput({v.name, "_req_we"}, 32'(mem_we), 32'(v.wr));
        checkOutput({v.name, "_req_wstrb"}, 32'(mem_wstrb), 32'(v.expWstrb));
        if (v.wr) checkOutput({v.name, "_req_wdata"}, mem_wdata, v.expWdata);
        mem_ready = (k == v.delay);
        mem_err   = v.err;
        mem_rdata = (k == v.delay) ? v.rdata : $urandom;
        sbread    = (k == 0);
        @(posedge clk); #1;
      end
      mem_ready = 1'b0; mem_err = 1'b0; sbread = 1'b0;
      checkOutput({v.name, "_resp_valid"}, 32'(mem_valid), 32'd0);
      checkOutput({v.name, "_resp_busy"}, 32'(sbbusy), 32'd0);
      checkOutput({v.name, "_resp_err"}, 32'(sberror), 32'(v.expErr));
      checkOutput({v.name, "_resp_data"}, sbdata_i, v.expRdata);
    end
    @(posedge clk); #1;
    checkOutput({v.name, "_idle_busy"}, 32'(sbbusy), 32'd0);
    checkOutput({v.name, "_idle_valid"}, 32'(mem_valid), 32'd0);
    checkOutput({v.name, "_hold_err"}, 32'(sberror), 32'(v.expErr));
    checkOutput({v.name, "_hold_data"}, sbdata_i, v.expRdata);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valid"}, 32'(mem_valid), 32'd0);
    checkOutput({tag, "_busy"}, 32'(sbbusy), 32'd0);
    checkOutput({tag, "_err"}, 32'(sberror), 32'd0);
    checkOutput({tag, "_data"}, sbdata_i, 32'd0);
    checkOutput({tag, "_we"}, 32'(mem_we), 32'd0);
    checkOutput({tag, "_addr"}, mem_addr, 32'd0);
    checkOutput({tag, "_wdata"}, mem_wdata, 32'd0);
    checkOutput({tag, "_wstrb"}, 32'(mem_wstrb), 32'd0);
  endtask

  vec_t vecs[14];
  vec_t rv;
  int   r;

  initial begin
    vecs[0]  = mkVec("word_write",     32'h1000_0008, 32'hDEAD_BEEF, 3'd2, 1'b0, 1'b1, 2,  32'h0,         1'b0, 1'b0, 32'h0,         4'hF, 32'hDEAD_BEEF);
    vecs[1]  = mkVec("byte_read",      32'h1000_0003, 32'h0,         3'd0, 1'b1, 1'b0, 0,  32'h1122_3344, 1'b0, 1'b0, 32'h0000_0011, 4'h0, 32'h0);
    vecs[2]  = mkVec("half_write",     32'h1000_0002, 32'h0000_ABCD, 3'd1, 1'b0, 1'b1, 1,  32'h0,         1'b0, 1'b0, 32'h0,         4'hC, 32'hABCD_ABCD);
    vecs[3]  = mkVec("word_misalign",  32'h1000_0001, 32'h0,         3'd2, 1'b1, 1'b0, 0,  32'h0,         1'b0, 1'b1, 32'h0,         4'h0, 32'h0);
    vecs[4]  = mkVec("size3",          32'h1000_0000, 32'h0,         3'd3, 1'b1, 1'b0, 0,  32'h0,         1'b0, 1'b1, 32'h0,         4'h0, 32'h0);
    vecs[5]  = mkVec("read_bus_err",   32'h1000_0010, 32'h0,         3'd2, 1'b1, 1'b0, 1,  32'hCAFE_F00D, 1'b1, 1'b1, 32'h0,         4'h0, 32'h0);
    vecs[6]  = mkVec("read_timeout",   32'h1000_0014, 32'h0,         3'd2, 1'b1, 1'b0, 50, 32'h0,         1'b0, 1'b1, 32'h0,         4'h0, 32'h0);
    vecs[7]  = mkVec("rd_and_wr",      32'h1000_0000, 32'h0,         3'd2, 1'b1, 1'b1, 0,  32'h0,         1'b0, 1'b1, 32'h0,         4'h0, 32'h0);
    vecs[8]  = mkVec("byte_write",     32'h1000_0001, 32'h1234_5678, 3'd0, 1'b0, 1'b1, 0,  32'h0,         1'b0, 1'b0, 32'h0,         4'h2, 32'h7878_7878);
    vecs[9]  = mkVec("half_read_hi",   32'h1000_0006, 32'h0,         3'd1, 1'b1, 1'b0, 0,  32'hAABB_CCDD, 1'b0, 1'b0, 32'h0000_AABB, 4'h0, 32'h0);
    vecs[10] = mkVec("half_misalign",  32'h1000_0003, 32'h0000_1111, 3'd1, 1'b0, 1'b1, 0,  32'h0,         1'b0, 1'b1, 32'h0,         4'h0, 32'h0);
    vecs[11] = mkVec("ready_at_limit", 32'h1000_001C, 32'h0,         3'd2, 1'b1, 1'b0, 3,  32'h0102_0304, 1'b0, 1'b0, 32'h0102_0304, 4'h0, 32'h0);
    vecs[12] = mkVec("write_bus_err",  32'h1000_0020, 32'h0000_005A, 3'd0, 1'b0, 1'b1, 0,  32'h0,         1'b1, 1'b1, 32'h0,         4'h1, 32'h5A5A_5A5A);
    vecs[13] = mkVec("byte_read_ln1",  32'h1000_0005, 32'h0,         3'd0, 1'b1, 1'b0, 0,  32'h1122_3344, 1'b0, 1'b0, 32'h0000_0033, 4'h0, 32'h0);

    rst = 1'b1;
    sbaddr = 32'h0; sbdata_o = 32'h0; sbsize = 3'd0; sbread = 1'b0; sbwrite = 1'b0;
    mem_ready = 1'b0; mem_rdata = 32'h0; mem_err = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    checkAllZero("reset");

    for (int i = 0; i < 14; i++) applyStimulus(vecs[i]);

    // Reset while a write is on the bus: everything clears at once, next transfer is normal.
    sbaddr = 32'h2000_0004; sbdata_o = 32'h1234_5678; sbsize = 3'd2; sbwrite = 1'b1;
    @(posedge clk); #1;
    sbwrite = 1'b0;
    checkOutput("midreq_valid_before", 32'(mem_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkAllZero("midreq_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(mkVec("after_reset", 32'h2000_0008, 32'h0, 3'd2, 1'b1, 1'b0, 1, 32'h5566_7788,
                        1'b0, 1'b0, 32'h5566_7788, 4'h0, 32'h0));

    for (int n = 0; n < 60; n++) begin
      rv.name  = $sformatf("rand%0d", n);
      rv.size  = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      rv.addr  = $urandom;
      if (rv.size <= 3'd2 && $urandom_range(0, 3) != 0) rv.addr = rv.addr & ~((32'd1 << rv.size) - 32'd1);
      r = $urandom_range(0, 9);
      rv.rd    = (r == 0) || (r < 5);
      rv.wr    = (r == 0) || (r >= 5);
      rv.data  = $urandom;
      rv.rdata = $urandom;
      rv.delay = $urandom_range(0, 5);
      rv.err   = ($urandom_range(0, 7) == 0);
      rv = fillExpected(rv);
      applyStimulus(rv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/debug_sbus_responder.md
# debug_sbus_responder

Responder end of the debug system bus: accepts single-cycle `sbread`/`sbwrite` pulses from the debug module's system bus master and executes each as one transaction on the SoC's word-wide valid/ready memory bus. It handles the 8-, 16- and 32-bit lanes in both directions: byte strobes and data replication on writes, extraction on reads. It drives `sbbusy`, `sbdata_i` and `sberror` back to the debug module with the timing that module samples. Misaligned accesses, illegal sizes, bus errors and bus hangs all return `sberror` instead of stalling JTAG.

## Interface
- TIMEOUT_CYCLES, 1023: max cycles `mem_valid` may wait for `mem_ready`; 0 disables the timeout.
- TO_W, 10: timeout counter width; must satisfy TIMEOUT_CYCLES < 2^TO_W.
- clk  in  1  single clock; all logic in this domain.
- rst  in  1  asynchronous, active-high reset.
- sbaddr  in  32  byte address, sampled in the request cycle.
- sbdata_o  in  32  write data, right-justified, sampled in the request cycle.
- sbsize  in  3  0=byte, 1=half, 2=word, sampled in the request cycle.
- sbread  in  1  one-cycle read request pulse.
- sbwrite  in  1  one-cycle write request pulse.
- sbdata_i  out  32  read data, right-justified, zero-extended.
- sbbusy  out  1  transaction in progress.
- sberror  out  1  transaction failed.
- mem_valid  out  1  request valid; held until `mem_ready` or timeout.
- mem_we  out  1  1=write.
- mem_addr  out  32  word address: {sbaddr[31:2], 2'b00}.
- mem_wdata  out  32  lane-replicated write data.
- mem_wstrb  out  4  byte enables; 4'b0000 on reads.
- mem_ready  in  1  completes the transaction in the cycle it is high with `mem_valid`.
- mem_rdata  in  32  read word, valid with `mem_ready`.
- mem_err  in  1  bus error, valid with `mem_ready`.

## Operation
- States: IDLE, REQ, RESP.
- `sbbusy` = (state != IDLE && state != RESP) || ((sbread || sbwrite) && state == IDLE). It is combinational so it is already high in the pulse cycle.
- **Accept (IDLE, sbread or sbwrite high)**
  - Latch address, size, data and direction.
  - Clear `sberror` and `sbdata_i` to 0.
  - Run the legality check, then go to REQ if legal, else RESP with `sberror`=1 and no bus access.
- **Illegal requests**
  - `sbsize` > 2.
  - Half access with addr[0]=1.
  - Word access with addr[1:0] != 0.
  - `sbread` and `sbwrite` both high.
- **Write lanes**
  - Byte: wdata = {4{d[7:0]}}, wstrb = 4'b0001 << addr[1:0].
  - Half: wdata = {2{d[15:0]}}, wstrb = addr[1] ? 4'b1100 : 4'b0011.
  - Word: wdata = d, wstrb = 4'b1111.
- **Read extraction**
  - Byte: `mem_rdata` >> (8*addr[1:0]), masked to 8 bits.
  - Half: `mem_rdata` >> (16*addr[1]), masked to 16 bits.
  - Word: unmasked.
  - Upper bits are zero.
- **REQ**
  - `mem_valid`=1; `mem_we`, `mem_addr`, `mem_wdata` and `mem_wstrb` stay constant.
  - The timeout counter increments each REQ cycle.
  - On `mem_ready`: capture read data (reads only), set `sberror` = `mem_err`, drop `mem_valid`, go to RESP.
  - On timeout (counter == TIMEOUT_CYCLES, nonzero, with no `mem_ready`): drop `mem_valid`, set `sberror`=1, go to RESP.
  - When `mem_ready` coincides with the timeout cycle, `mem_ready` wins.
- **RESP**
  - One cycle with `sbbusy`=0; then IDLE.
  - `sbdata_i` and `sberror` hold until the next accept.
  - A request pulse arriving in RESP is ignored; the master cannot issue one there.
- Request pulses during REQ are ignored.
- Error on a read: `sbdata_i` = 0. When `mem_err` is set, `mem_rdata` is discarded.

## Timing
- Reset values: state IDLE; `mem_valid`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_wstrb`, `sbdata_i` and `sberror` all 0. `sbbusy` is 0 because there is no pulse.
- Reset mid-REQ drops `mem_valid` asynchronously; no response is produced.
- Pulse in cycle N; `mem_valid` first high in N+1.
- `mem_ready` in cycle M ≥ N+1; RESP (`sbbusy`=0, data/error valid) in M+1; IDLE from M+2.
- Zero-wait bus: the `sbbusy` low cycle is N+2.
- Illegal request: RESP in N+1; no `mem_valid`.
- Timeout: `mem_valid` is high for exactly TIMEOUT_CYCLES cycles, then RESP.
- Next accept is possible from M+2. The master's pulse cannot arrive earlier.

## Test plan
- **Word write:** sbwrite, addr 0x1000_0008, data 0xDEADBEEF, size 2; ready in 3rd REQ cycle.
  - Expect `mem_wstrb`=4'hF, `mem_addr`=0x1000_0008, `mem_valid` high 3 cycles.
  - Expect `sbbusy` low 1 cycle later, `sberror`=0.
- **Byte read:** addr 0x1000_0003, size 0, `mem_rdata`=0x11223344, zero wait.
  - Expect `sbdata_i`=0x0000_0011 with `sbbusy` low at N+2.
- **Half write:** addr 0x…02, data 0x0000_ABCD.
  - Expect `mem_wdata`=0xABCDABCD, `mem_wstrb`=4'b1100.
- **Illegal requests:**
  - Word read at 0x…01 → `sberror`=1 in N+1, `mem_valid` never high.
  - `sbsize`=3 → same.
- **Bus error and timeout:**
  - `mem_err`=1 with `mem_ready` on a read → `sberror`=1, `sbdata_i`=0.
  - TIMEOUT_CYCLES=4 and `mem_ready` held 0 → `mem_valid` high exactly 4 cycles, then `sberror`=1.
- **Reset mid-REQ:** assert `rst` with `mem_valid` high.
  - Expect `mem_valid`=0 immediately, all outputs 0.
  - The next request completes normally.
